// File: rtl/eth_tx_reply_arbiter.sv
// eth_tx_reply_arbiter
//   Round-robin scheduler that shares the single 64-bit AXI-Stream TX port
//   among the ARP, ICMP and UDP reply streams. It sits between the reply
//   builders and the 10G MAC TX. One source is granted at a time, and the
//   grant is held until that frame's tlast beat is accepted. The block also
//   counts transmitted frames and flags frames that run over length.
//
// Parameters
//   MAX_BEATS   beat limit per frame; reaching it without tlast sets o_err_overrun
//   IFG_CYCLES  idle cycles forced after each frame (only with ETH_TX_ARB_IFG_EN)
//
// Configuration macro
//   ETH_TX_ARB_IFG_EN  when defined, an IFG state holds the port idle for
//                      IFG_CYCLES cycles after every frame
//
// Ports
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_<src>_tvalid/tdata/tlast/tkeep, o_<src>_tready
//                                  reply streams, src = arp, icmp, udp
//   o_tx_axis_tvalid/tdata/tlast/tkeep, i_tx_axis_tready
//                                  stream towards the MAC
//   o_grant        one-hot active grant {udp,icmp,arp}, 0 when idle
//   o_busy         1 in any state other than IDLE
//   o_frame_cnt    frames completed, wraps at 16 bits
//   o_err_overrun  sticky over-length flag, cleared only by reset
module eth_tx_reply_arbiter #(
  parameter int MAX_BEATS  = 1024,
  parameter int IFG_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_arp_tvalid,
  input  logic [63:0] i_arp_tdata,
  input  logic        i_arp_tlast,
  input  logic [7:0]  i_arp_tkeep,
  output logic        o_arp_tready,
  input  logic        i_icmp_tvalid,
  input  logic [63:0] i_icmp_tdata,
  input  logic        i_icmp_tlast,
  input  logic [7:0]  i_icmp_tkeep,
  output logic        o_icmp_tready,
  input  logic        i_udp_tvalid,
  input  logic [63:0] i_udp_tdata,
  input  logic        i_udp_tlast,
  input  logic [7:0]  i_udp_tkeep,
  output logic        o_udp_tready,
  output logic        o_tx_axis_tvalid,
  output logic [63:0] o_tx_axis_tdata,
  output logic        o_tx_axis_tlast,
  output logic [7:0]  o_tx_axis_tkeep,
  input  logic        i_tx_axis_tready,
  output logic [2:0]  o_grant,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt,
  output logic        o_err_overrun
);

`ifdef ETH_TX_ARB_IFG_EN
  localparam int IFG_LEN = IFG_CYCLES;
`else
  // IFG disabled: IFG_CYCLES is ignored and the IFG state is never entered.
  localparam int IFG_LEN = IFG_CYCLES * 0;
`endif

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int IW = (IFG_LEN > 0) ? $clog2(IFG_LEN + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    IFG  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [2:0]    grant, grant_next;
  logic [2:0]    rr_ptr, rr_ptr_next;
  logic [2:0]    req, winner, rdy;
  logic          sel_valid, sel_last;
  logic [63:0]   sel_data;
  logic [7:0]    sel_keep;
  logic          tx_valid, accept, last_accept;
  logic [BW-1:0] beat_cnt;
  logic [15:0]   frame_cnt;
  logic          err_overrun;
  logic [IW-1:0] ifg_cnt;

  assign req = {i_udp_tvalid, i_icmp_tvalid, i_arp_tvalid};

  // Search starts at the source after the last winner: ARP -> ICMP -> UDP -> ARP.
  always_comb begin
    winner = 3'b000;
    case (rr_ptr)
      3'b001: begin
        if      (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
      end
      3'b010: begin
        if      (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
      end
      default: begin
        if      (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
      end
    endcase
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    if (grant[0]) begin
      sel_valid = i_arp_tvalid;
      sel_last  = i_arp_tlast;
      sel_data  = i_arp_tdata;
      sel_keep  = i_arp_tkeep;
    end else if (grant[1]) begin
      sel_valid = i_icmp_tvalid;
      sel_last  = i_icmp_tlast;
      sel_data  = i_icmp_tdata;
      sel_keep  = i_icmp_tkeep;
    end else if (grant[2]) begin
      sel_valid = i_udp_tvalid;
      sel_last  = i_udp_tlast;
      sel_data  = i_udp_tdata;
      sel_keep  = i_udp_tkeep;
    end
  end

  assign tx_valid    = (state == XFER) && sel_valid;
  assign accept      = tx_valid && i_tx_axis_tready;
  assign last_accept = accept && sel_last;

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_next  = winner;
          rr_ptr_next = winner;
          state_next  = XFER;
        end
      end
      XFER: begin
        if (last_accept) begin
          grant_next = 3'b000;
          state_next = (IFG_LEN > 0) ? IFG : IDLE;
        end
      end
      IFG: begin
        if (ifg_cnt <= IW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointer resets to UDP so that ARP wins the first arbitration.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      grant  <= 3'b000;
      rr_ptr <= 3'b100;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ifg_cnt <= '0;
    end else if (last_accept) begin
      ifg_cnt <= IW'(IFG_LEN);
    end else if (state == IFG && ifg_cnt != '0) begin
      ifg_cnt <= ifg_cnt - 1'b1;
    end
  end

  // The overrun flag is raised by the non-last beat that brings the count
  // to MAX_BEATS; the frame itself keeps flowing until its tlast.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      beat_cnt    <= '0;
      frame_cnt   <= '0;
      err_overrun <= 1'b0;
    end else if (accept) begin
      if (sel_last) begin
        beat_cnt  <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        if (beat_cnt < BW'(MAX_BEATS)) beat_cnt <= beat_cnt + 1'b1;
        if (beat_cnt >= BW'(MAX_BEATS - 1)) err_overrun <= 1'b1;
      end
    end
  end

  assign rdy = (state == XFER && i_tx_axis_tready) ? grant : 3'b000;

  assign o_arp_tready     = rdy[0];
  assign o_icmp_tready    = rdy[1];
  assign o_udp_tready     = rdy[2];
  assign o_tx_axis_tvalid = tx_valid;
  assign o_tx_axis_tdata  = tx_valid ? sel_data : 64'd0;
  assign o_tx_axis_tlast  = tx_valid && sel_last;
  assign o_tx_axis_tkeep  = tx_valid ? sel_keep : 8'd0;
  assign o_grant          = grant;
  assign o_busy           = (state != IDLE);
  assign o_frame_cnt      = frame_cnt;
  assign o_err_overrun    = err_overrun;

endmodule

// File: tb/tb_eth_tx_reply_arbiter.sv
// tb_eth_tx_reply_arbiter
//   Self-checking bench for eth_tx_reply_arbiter. The DUT is built with
//   MAX_BEATS=4 so that over-length frames are short. A cycle table covers
//   pass-through, tready toggling, source stalls and overrun. Hand-written
//   sequences cover round-robin ordering, the inter-frame gap, reset in the
//   middle of a frame and the sticky overrun flag.
module tb_eth_tx_reply_arbiter;

  localparam int MAXB = 4;
  localparam int IFGC = 2;
`ifdef ETH_TX_ARB_IFG_EN
  localparam int GAP = IFGC + 2;
`else
  localparam int GAP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        arp_valid, arp_last, arp_ready;
  logic [63:0] arp_data;
  logic [7:0]  arp_keep;
  logic        icmp_valid, icmp_last, icmp_ready;
  logic [63:0] icmp_data;
  logic [7:0]  icmp_keep;
  logic        udp_valid, udp_last, udp_ready;
  logic [63:0] udp_data;
  logic [7:0]  udp_keep;
  logic        tx_valid, tx_last, tx_ready;
  logic [63:0] tx_data;
  logic [7:0]  tx_keep;
  logic [2:0]  grant;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_overrun;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  eth_tx_reply_arbiter #(.MAX_BEATS(MAXB), .IFG_CYCLES(IFGC)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_arp_tvalid(arp_valid), .i_arp_tdata(arp_data), .i_arp_tlast(arp_last),
    .i_arp_tkeep(arp_keep), .o_arp_tready(arp_ready),
    .i_icmp_tvalid(icmp_valid), .i_icmp_tdata(icmp_data), .i_icmp_tlast(icmp_last),
    .i_icmp_tkeep(icmp_keep), .o_icmp_tready(icmp_ready),
    .i_udp_tvalid(udp_valid), .i_udp_tdata(udp_data), .i_udp_tlast(udp_last),
    .i_udp_tkeep(udp_keep), .o_udp_tready(udp_ready),
    .o_tx_axis_tvalid(tx_valid), .o_tx_axis_tdata(tx_data), .o_tx_axis_tlast(tx_last),
    .o_tx_axis_tkeep(tx_keep), .i_tx_axis_tready(tx_ready),
    .o_grant(grant), .o_busy(busy), .o_frame_cnt(frame_cnt), .o_err_overrun(err_overrun)
  );

  typedef struct {
    logic [2:0] v;
    logic [2:0] l;
    int         b;
    logic       txr;
    logic       ev;
    logic       el;
    logic [2:0] eg;
    logic [2:0] er;
    logic       eb;
    int         ef;
    logic       ee;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [7:0]  k;
  } beat_t;

  vec_t  tbl[$];
  beat_t expQ[$];
  int    modelFrames;
  logic  modelErr;

  function automatic logic [63:0] srcData(input int s, input int b);
    logic [7:0] tag;
    tag = 8'hA0 + 8'(s);
    return {tag, 8'h5C, 16'(b), 32'hC0FFEE00 + 32'(b * 3)};
  endfunction

  function automatic logic [7:0] keepLast(input int s);
    case (s)
      0:       return 8'h0F;
      1:       return 8'h03;
      default: return 8'h3F;
    endcase
  endfunction

  function automatic int gidx(input logic [2:0] g);
    case (g)
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] l, input int b,
                              input logic txr, input logic ev, input logic el,
                              input logic [2:0] eg, input logic [2:0] er, input logic eb,
                              input int ef, input logic ee);
    vec_t r;
    r.v = v; r.l = l; r.b = b; r.txr = txr; r.ev = ev; r.el = el;
    r.eg = eg; r.er = er; r.eb = eb; r.ef = ef; r.ee = ee;
    return r;
  endfunction

  function automatic beat_t mkBeat(input int s, input int b, input logic l);
    beat_t r;
    r.d = srcData(s, b);
    r.l = l;
    r.k = l ? keepLast(s) : 8'hFF;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic driveSrc(input int s, input logic v, input int b, input logic l);
    case (s)
      0: begin
        arp_valid = v; arp_data = srcData(0, b); arp_last = l;
        arp_keep = l ? keepLast(0) : 8'hFF;
      end
      1: begin
        icmp_valid = v; icmp_data = srcData(1, b); icmp_last = l;
        icmp_keep = l ? keepLast(1) : 8'hFF;
      end
      default: begin
        udp_valid = v; udp_data = srcData(2, b); udp_last = l;
        udp_keep = l ? keepLast(2) : 8'hFF;
      end
    endcase
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] v, input logic [2:0] l,
                               input int b, input logic txr);
    rst = r;
    for (int s = 0; s < 3; s++) driveSrc(s, v[s], b, l[s]);
    tx_ready = txr;
  endtask

  task automatic resetDut();
    @(negedge clk);
    applyStimulus(1'b1, 3'b000, 3'b000, 0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 3'b000, 3'b000, 0, 1'b1);
    #1;
  endtask

  // Sources behave as AXI masters that advance on their own handshake; the
  // expected output beats, frame count and overrun flag come from expQ and
  // a small frame-length model.
  task automatic runSources(input int lenA, input int lenI, input int lenU, input int maxCycles);
    int len[3];
    int beat[3];
    int cyc, lastT, frameBeats, stray, nextFrames;
    logic nextErr;
    logic [2:0] vld, rdy;
    beat_t e;
    len = '{lenA, lenI, lenU};
    beat = '{0, 0, 0};
    cyc = 0; lastT = -1; frameBeats = 0; stray = 0;
    while (expQ.size() != 0 && cyc < maxCycles) begin
      @(negedge clk);
      rst = 1'b0;
      tx_ready = 1'b1;
      for (int s = 0; s < 3; s++) begin
        vld[s] = beat[s] < len[s];
        driveSrc(s, vld[s], beat[s], beat[s] == len[s] - 1);
      end
      #1;
      rdy = {udp_ready, icmp_ready, arp_ready};
      if ($countones(rdy) > 1) stray++;
      checkOutput("frame_cnt", 64'(frame_cnt), 64'(modelFrames));
      checkOutput("err_overrun", 64'(err_overrun), 64'(modelErr));
      if (tx_valid && lastT >= 0) begin
        checkOutput("inter-frame gap", 64'(cyc - lastT), 64'(GAP));
        lastT = -1;
      end
      nextFrames = modelFrames;
      nextErr = modelErr;
      if (tx_valid && tx_ready) begin
        e = expQ.pop_front();
        checkOutput("beat data", tx_data, e.d);
        checkOutput("beat last", 64'(tx_last), 64'(e.l));
        checkOutput("beat keep", 64'(tx_keep), 64'(e.k));
        if (e.l) begin
          nextFrames = modelFrames + 1;
          frameBeats = 0;
          lastT = cyc;
        end else begin
          frameBeats++;
          if (frameBeats >= MAXB) nextErr = 1'b1;
        end
      end
      @(posedge clk);
      for (int s = 0; s < 3; s++) if (vld[s] && rdy[s]) beat[s]++;
      modelFrames = nextFrames;
      modelErr = nextErr;
      cyc++;
    end
    if (expQ.size() != 0) begin
      checkOutput("beats left at timeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
    checkOutput("more than one tready high", 64'(stray), 64'd0);
    repeat (4) begin
      @(negedge clk);
      applyStimulus(1'b0, 3'b000, 3'b000, 0, 1'b1);
    end
    #1;
    checkOutput("frame_cnt after drain", 64'(frame_cnt), 64'(modelFrames));
    checkOutput("err_overrun after drain", 64'(err_overrun), 64'(modelErr));
  endtask

  initial begin
    vec_t r;
    int src;
    applyStimulus(1'b1, 3'b000, 3'b000, 0, 1'b0);
    resetDut();

    // Reset state, with the MAC ready and nobody requesting.
    checkOutput("reset tvalid", 64'(tx_valid), 64'd0);
    checkOutput("reset tdata", tx_data, 64'd0);
    checkOutput("reset tkeep", 64'(tx_keep), 64'd0);
    checkOutput("reset tlast", 64'(tx_last), 64'd0);
    checkOutput("reset grant", 64'(grant), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset readies", 64'({udp_ready, icmp_ready, arp_ready}), 64'd0);
    checkOutput("reset frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("reset err_overrun", 64'(err_overrun), 64'd0);

    // ICMP 4-beat frame with tready toggling, then an ARP 6-beat frame with
    // a source stall; ICMP keeps requesting but must never be granted.
    tbl.push_back(mk(3'b010, 3'b000, 0, 1, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 0, 1, 1, 0, 3'b010, 3'b010, 1, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 1, 0, 1, 0, 3'b010, 3'b000, 1, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 1, 1, 1, 0, 3'b010, 3'b010, 1, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 2, 0, 1, 0, 3'b010, 3'b000, 1, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 2, 1, 1, 0, 3'b010, 3'b010, 1, 0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 3, 0, 1, 1, 3'b010, 3'b000, 1, 0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 3, 1, 1, 1, 3'b010, 3'b010, 1, 0, 0));
`ifdef ETH_TX_ARB_IFG_EN
    repeat (IFGC) tbl.push_back(mk(3'b000, 3'b000, 0, 1, 0, 0, 3'b000, 3'b000, 1, 1, 0));
`endif
    tbl.push_back(mk(3'b001, 3'b000, 0, 1, 0, 0, 3'b000, 3'b000, 0, 1, 0));
    tbl.push_back(mk(3'b011, 3'b000, 0, 1, 1, 0, 3'b001, 3'b001, 1, 1, 0));
    tbl.push_back(mk(3'b011, 3'b000, 1, 1, 1, 0, 3'b001, 3'b001, 1, 1, 0));
    tbl.push_back(mk(3'b010, 3'b000, 2, 1, 0, 0, 3'b001, 3'b001, 1, 1, 0));
    tbl.push_back(mk(3'b011, 3'b000, 2, 1, 1, 0, 3'b001, 3'b001, 1, 1, 0));
    tbl.push_back(mk(3'b011, 3'b000, 3, 1, 1, 0, 3'b001, 3'b001, 1, 1, 0));
    tbl.push_back(mk(3'b011, 3'b000, 4, 1, 1, 0, 3'b001, 3'b001, 1, 1, 1));
    tbl.push_back(mk(3'b011, 3'b001, 5, 1, 1, 1, 3'b001, 3'b001, 1, 1, 1));
`ifdef ETH_TX_ARB_IFG_EN
    repeat (IFGC) tbl.push_back(mk(3'b000, 3'b000, 0, 1, 0, 0, 3'b000, 3'b000, 1, 2, 1));
`endif
    tbl.push_back(mk(3'b000, 3'b000, 0, 1, 0, 0, 3'b000, 3'b000, 0, 2, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      @(negedge clk);
      applyStimulus(1'b0, r.v, r.l, r.b, r.txr);
      #1;
      src = gidx(r.eg);
      checkOutput($sformatf("row%0d tvalid", i), 64'(tx_valid), 64'(r.ev));
      checkOutput($sformatf("row%0d tdata", i), tx_data, r.ev ? srcData(src, r.b) : 64'd0);
      checkOutput($sformatf("row%0d tlast", i), 64'(tx_last), 64'(r.el));
      checkOutput($sformatf("row%0d tkeep", i), 64'(tx_keep),
                  64'(r.ev ? (r.el ? keepLast(src) : 8'hFF) : 8'h00));
      checkOutput($sformatf("row%0d grant", i), 64'(grant), 64'(r.eg));
      checkOutput($sformatf("row%0d readies", i), 64'({udp_ready, icmp_ready, arp_ready}), 64'(r.er));
      checkOutput($sformatf("row%0d busy", i), 64'(busy), 64'(r.eb));
      checkOutput($sformatf("row%0d frame_cnt", i), 64'(frame_cnt), 64'(r.ef));
      checkOutput($sformatf("row%0d err_overrun", i), 64'(err_overrun), 64'(r.ee));
    end

    // All three sources request at reset exit: ARP, ICMP, UDP, no interleave.
    resetDut();
    modelFrames = 0;
    modelErr = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int b = 0; b < 3; b++) expQ.push_back(mkBeat(s, b, b == 2));
    runSources(3, 3, 3, 200);

    // Reset while ICMP is presenting beat 2 of a 5-beat frame.
    @(negedge clk);
    applyStimulus(1'b0, 3'b010, 3'b000, 0, 1'b1);
    #1;
    checkOutput("pre-reset idle tvalid", 64'(tx_valid), 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, 3'b010, 3'b000, 0, 1'b1);
    #1;
    checkOutput("pre-reset grant", 64'(grant), 64'b010);
    @(negedge clk);
    applyStimulus(1'b0, 3'b010, 3'b000, 1, 1'b1);
    #1;
    checkOutput("pre-reset frame_cnt", 64'(frame_cnt), 64'd3);
    @(negedge clk);
    applyStimulus(1'b1, 3'b010, 3'b000, 2, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 3'b111, 3'b000, 0, 1'b1);
    #1;
    checkOutput("post-reset tvalid", 64'(tx_valid), 64'd0);
    checkOutput("post-reset grant", 64'(grant), 64'd0);
    checkOutput("post-reset frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("post-reset busy", 64'(busy), 64'd0);
    checkOutput("post-reset readies", 64'({udp_ready, icmp_ready, arp_ready}), 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, 3'b111, 3'b000, 0, 1'b1);
    #1;
    checkOutput("post-reset first grant", 64'(grant), 64'b001);
    checkOutput("post-reset first tdata", tx_data, srcData(0, 0));

    // UDP 6-beat frame against MAX_BEATS=4: flag after the 4th beat, all
    // beats still delivered, flag held until reset.
    resetDut();
    modelFrames = 0;
    modelErr = 1'b0;
    for (int b = 0; b < 6; b++) expQ.push_back(mkBeat(2, b, b == 5));
    runSources(0, 0, 6, 100);
    checkOutput("overrun sticky while idle", 64'(err_overrun), 64'd1);
    resetDut();
    checkOutput("overrun cleared by reset", 64'(err_overrun), 64'd0);
    checkOutput("frame_cnt cleared by reset", 64'(frame_cnt), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
